// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer:
// FSM state encoding, the x0 index and the stage-control bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hzd_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic flush_ifid;
    logic en_idex;
    logic flush_idex;
    logic en_exmem;
  } ctrl_t;

  localparam ctrl_t CTRL_NORM   = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b0,
                                    en_idex: 1'b1, flush_idex: 1'b0, en_exmem: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{en_pc: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                    en_idex: 1'b0, flush_idex: 1'b0, en_exmem: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{en_pc: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b1,
                                    en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{en_pc: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                    en_idex: 1'b1, flush_idex: 1'b1, en_exmem: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the pipeline and stage controls back to it.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic [4:0]       rd_EX;
  logic             memread_EX;
  logic             redirect_EX;
  // Data-memory handshake: an access in MEM with mem_req_MEM=1 completes in the
  // cycle mem_ready_MEM=1; every cycle with mem_req_MEM=1 and mem_ready_MEM=0 is a wait.
  logic             mem_req_MEM;
  logic             mem_ready_MEM;
  logic             en_PC;
  logic             en_IFID;
  logic             flush_IFID;
  logic             en_IDEX;
  logic             flush_IDEX;
  logic             en_EXMEM;
  logic [CNT_W-1:0] stall_cnt;
  hzd_state_t       state;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, memread_EX,
           redirect_EX, mem_req_MEM, mem_ready_MEM,
    input  en_PC, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM,
           stall_cnt, state
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, memread_EX,
           redirect_EX, mem_req_MEM, mem_ready_MEM,
    output en_PC, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM,
           stall_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: the load in EX writes a register the
// instruction in ID reads. Writes to x0 never create a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [4:0] rd_EX,
  input  logic       memread_EX,
  output logic       luh
);
  logic dep_rs1;
  logic dep_rs2;

  assign dep_rs1 = rs1_used_ID && (rs1_ID == rd_EX);
  assign dep_rs2 = rs2_used_ID && (rs2_ID == rd_EX);
  assign luh     = memread_EX && (rd_EX != REG_X0) && (dep_rs1 || dep_rs2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Controls are combinational
// from state and inputs; state, flush counter and stall counter move on posedge.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
)(
  input  logic               clk_HZD,
  input  logic               rst_HZD,
  pipe_hazard_ctrl_if.slave  hz
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hzd_state_t       state, state_nxt;
  logic [1:0]       fcnt, fcnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  ctrl_t            ctrl;
  logic             luh;
  logic             mw;

  hazard_detect u_hazard_detect (
    .rs1_ID      (hz.rs1_ID),
    .rs2_ID      (hz.rs2_ID),
    .rs1_used_ID (hz.rs1_used_ID),
    .rs2_used_ID (hz.rs2_used_ID),
    .rd_EX       (hz.rd_EX),
    .memread_EX  (hz.memread_EX),
    .luh         (luh)
  );

  assign mw = hz.mem_req_MEM && !hz.mem_ready_MEM;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    ctrl      = CTRL_NORM;
    case (state)
      FLUSH: begin
        // A memory wait freezes the flush sequence in place; it resumes afterwards.
        if (mw) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl = CTRL_FLUSH;
          if (fcnt <= 2'd1) begin
            state_nxt = RUN;
            fcnt_nxt  = 2'd0;
          end else begin
            fcnt_nxt = fcnt - 2'd1;
          end
        end
      end
      default: begin
        // RUN, and MEM_WAIT once the access completes, share the same rules.
        state_nxt = RUN;
        if (mw) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
        end else if (hz.redirect_EX) begin
          ctrl = CTRL_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FLUSH_LOAD;
          end
        end else if (luh) begin
          ctrl = CTRL_BUBBLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_HZD or posedge rst_HZD) begin
    if (rst_HZD) begin
      state     <= RUN;
      fcnt      <= 2'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (!ctrl.en_pc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign hz.en_PC      = ctrl.en_pc;
  assign hz.en_IFID    = ctrl.en_ifid;
  assign hz.flush_IFID = ctrl.flush_ifid;
  assign hz.en_IDEX    = ctrl.en_idex;
  assign hz.flush_IDEX = ctrl.flush_idex;
  assign hz.en_EXMEM   = ctrl.en_exmem;
  assign hz.stall_cnt  = stall_cnt;
  assign hz.state      = state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (FLUSH_CYCLES 2/3/1, one with a
// 4-bit counter) share stimulus; expected per-cycle controls go to a queue.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       req;
    logic       rdy;
  } in_t;

  // expected entry: {target[1:0], state[1:0], ctrl[5:0], stall_cnt[31:0]}
  localparam int W = 42;
  localparam logic [5:0] C_NORM = 6'b110101;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_FLS  = 6'b111111;
  localparam logic [5:0] C_BUB  = 6'b000111;

  logic clk_HZD;
  logic rst_HZD;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           compared;
  int           mismatched;
  event         sample_ev;

  pipe_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) if_b ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  if_c ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (.clk_HZD(clk_HZD), .rst_HZD(rst_HZD), .hz(if_a));
  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut_b (.clk_HZD(clk_HZD), .rst_HZD(rst_HZD), .hz(if_b));
  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut_c (.clk_HZD(clk_HZD), .rst_HZD(rst_HZD), .hz(if_c));

  // ---------------- clock / reset ----------------
  initial begin
    clk_HZD = 1'b0;
    forever #5 clk_HZD = ~clk_HZD;
  end

  // ---------------- driver tasks ----------------
  function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                             logic [4:0] rd, logic mr, logic redir, logic req, logic rdy);
    in_t v;
    v = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr,
          redir: redir, req: req, rdy: rdy};
    return v;
  endfunction

  task automatic apply(input in_t v);
    if_a.rs1_ID = v.rs1; if_a.rs2_ID = v.rs2; if_a.rs1_used_ID = v.u1; if_a.rs2_used_ID = v.u2;
    if_a.rd_EX = v.rd; if_a.memread_EX = v.mr; if_a.redirect_EX = v.redir;
    if_a.mem_req_MEM = v.req; if_a.mem_ready_MEM = v.rdy;
    if_b.rs1_ID = v.rs1; if_b.rs2_ID = v.rs2; if_b.rs1_used_ID = v.u1; if_b.rs2_used_ID = v.u2;
    if_b.rd_EX = v.rd; if_b.memread_EX = v.mr; if_b.redirect_EX = v.redir;
    if_b.mem_req_MEM = v.req; if_b.mem_ready_MEM = v.rdy;
    if_c.rs1_ID = v.rs1; if_c.rs2_ID = v.rs2; if_c.rs1_used_ID = v.u1; if_c.rs2_used_ID = v.u2;
    if_c.rd_EX = v.rd; if_c.memread_EX = v.mr; if_c.redirect_EX = v.redir;
    if_c.mem_req_MEM = v.req; if_c.mem_ready_MEM = v.rdy;
  endtask

  task automatic push_exp(input string tag, input logic [1:0] tgt, input logic [1:0] st,
                          input logic [5:0] ctl, input logic [31:0] cnt);
    exp_q.push_back({tgt, st, ctl, cnt});
    tag_q.push_back(tag);
  endtask

  // Called just after a posedge: drive one cycle of inputs and its expected response.
  task automatic cyc(input in_t v, input string tag, input logic [1:0] tgt,
                     input logic [1:0] st, input logic [5:0] ctl, input logic [31:0] cnt);
    apply(v);
    push_exp(tag, tgt, st, ctl, cnt);
    @(posedge clk_HZD);
    #1;
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_HZD = 1'b1;
    @(posedge clk_HZD);
    #1;
    rst_HZD = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic logic [39:0] act_of(logic [1:0] tgt);
    case (tgt)
      2'd0:    return {if_a.state, if_a.en_PC, if_a.en_IFID, if_a.flush_IFID,
                       if_a.en_IDEX, if_a.flush_IDEX, if_a.en_EXMEM, if_a.stall_cnt};
      2'd1:    return {if_b.state, if_b.en_PC, if_b.en_IFID, if_b.flush_IFID,
                       if_b.en_IDEX, if_b.flush_IDEX, if_b.en_EXMEM, if_b.stall_cnt};
      default: return {if_c.state, if_c.en_PC, if_c.en_IFID, if_c.flush_IFID,
                       if_c.en_IDEX, if_c.flush_IDEX, if_c.en_EXMEM, 28'd0, if_c.stall_cnt};
    endcase
  endfunction

  initial begin
    logic [W-1:0] e;
    logic [39:0]  act;
    string        tag;
    forever begin
      @(negedge clk_HZD or sample_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = act_of(e[41:40]);
        compared++;
        if (act !== e[39:0]) begin
          mismatched++;
          $display("FAIL %s: got state=%0d ctl=%b cnt=%0d, want state=%0d ctl=%b cnt=%0d",
                   tag, act[39:38], act[37:32], act[31:0], e[39:38], e[37:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t idle, redir, luh5, mwv, mrv, mem_luh_redir;
    compared   = 0;
    mismatched = 0;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    redir = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
    luh5  = mk(5, 0, 1, 0, 5, 1, 0, 0, 0);
    mwv   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    mrv   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    mem_luh_redir = mk(5, 0, 1, 0, 5, 1, 1, 1, 0);
    rst_HZD = 1'b1;
    apply(idle);
    @(posedge clk_HZD);
    #1;
    rst_HZD = 1'b0;

    // Instance A: FLUSH_CYCLES=2
    cyc(idle,                         "a_reset_idle",  0, RUN, C_NORM, 0);
    cyc(luh5,                         "a_luh_rs1",     0, RUN, C_BUB,  0);
    cyc(idle,                         "a_luh_release", 0, RUN, C_NORM, 1);
    cyc(mk(0, 0, 1, 0, 0, 1, 0, 0, 0), "a_luh_x0",     0, RUN, C_NORM, 1);
    cyc(mk(7, 7, 1, 1, 7, 1, 0, 0, 0), "a_luh_both",   0, RUN, C_BUB,  1);
    cyc(mk(3, 9, 1, 0, 9, 1, 0, 0, 0), "a_rs2_unused", 0, RUN, C_NORM, 2);
    cyc(mk(3, 9, 0, 1, 9, 1, 0, 0, 0), "a_luh_rs2",    0, RUN, C_BUB,  2);
    cyc(mk(9, 9, 1, 1, 9, 0, 0, 0, 0), "a_no_load",    0, RUN, C_NORM, 3);
    cyc(redir,                        "a_redir",       0, RUN,   C_FLS,  3);
    cyc(luh5,                         "a_flush_luh",   0, FLUSH, C_FLS,  3);
    cyc(idle,                         "a_flush_done",  0, RUN,   C_NORM, 3);
    cyc(mem_luh_redir,                "a_mw1",         0, RUN,      C_FRZ, 3);
    cyc(mem_luh_redir,                "a_mw2",         0, MEM_WAIT, C_FRZ, 4);
    cyc(mem_luh_redir,                "a_mw3",         0, MEM_WAIT, C_FRZ, 5);
    cyc(mk(5, 0, 1, 0, 5, 1, 1, 1, 1), "a_mw_ready",   0, MEM_WAIT, C_FLS, 6);
    cyc(idle,                         "a_mw_flush2",   0, FLUSH,    C_FLS,  6);
    cyc(idle,                         "a_mw_after",    0, RUN,      C_NORM, 6);
    cyc(mwv,                          "a_ar_mw1",      0, RUN,      C_FRZ,  6);
    cyc(mwv,                          "a_ar_mw2",      0, MEM_WAIT, C_FRZ,  7);
    // Now in MEM_WAIT with stall_cnt=8: reset between edges must act at once.
    #2;
    rst_HZD = 1'b1;
    #1;
    push_exp("a_async_rst", 0, RUN, C_FRZ, 0);
    -> sample_ev;
    #1;
    apply(idle);
    @(posedge clk_HZD);
    #1;
    rst_HZD = 1'b0;
    cyc(idle,                         "a_post_rst",    0, RUN, C_NORM, 0);

    // Instance B: FLUSH_CYCLES=3, memory wait in flush cycle 2
    do_reset();
    cyc(idle,  "b_idle",     1, RUN,   C_NORM, 0);
    cyc(redir, "b_redir",    1, RUN,   C_FLS,  0);
    cyc(mwv,   "b_fl_mw1",   1, FLUSH, C_FRZ,  0);
    cyc(mwv,   "b_fl_mw2",   1, FLUSH, C_FRZ,  1);
    cyc(mrv,   "b_fl_ready", 1, FLUSH, C_FLS,  2);
    cyc(idle,  "b_fl_last",  1, FLUSH, C_FLS,  2);
    cyc(idle,  "b_run",      1, RUN,   C_NORM, 2);

    // Instance C: FLUSH_CYCLES=1, 4-bit counter saturation
    do_reset();
    cyc(redir, "c_redir", 2, RUN, C_FLS,  0);
    cyc(idle,  "c_run",   2, RUN, C_NORM, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(mwv, "c_sat", 2, (i == 0) ? RUN : MEM_WAIT, C_FRZ, (i > 15) ? 32'd15 : 32'(i));
    end
    cyc(idle, "c_release", 2, MEM_WAIT, C_NORM, 15);
    cyc(idle, "c_idle",    2, RUN,      C_NORM, 15);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk_HZD);
      #1;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
